// File: rtl/slv_guard_rst_seq_pkg.sv
// Shared types for the guarded-subordinate reset sequencer: FSM states, reset causes,
// and sizing of the optional ack-timeout counter.
package slv_guard_rst_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIsolate,
        StDrain,
        StReq,
        StHold,
        StCool
    } state_e;

    typedef enum logic [1:0] {
        CauseNone    = 2'd0,
        CauseFault   = 2'd1,
        CauseSw      = 2'd2,
        CauseDrainTo = 2'd3
    } cause_e;

    localparam int AckTimeoutDefault = 1024;

    function automatic int ack_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int AckCntWidth = ack_cnt_width(AckTimeoutDefault);

endpackage

// File: rtl/slv_guard_timer.sv
// Loadable down-counter that stops at zero; shared by the drain and cooldown phases.
module slv_guard_timer #(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] val_i,
    output logic                zero_o
);

    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/slv_guard_rst_seq.sv
// Reset sequencer for one guarded subordinate port: isolate, drain, reset handshake, cooldown.
// Optional ack watchdog on the reset handshake: define SLV_GUARD_RST_SEQ_ACK_TIMEOUT_EN.
module slv_guard_rst_seq
    import slv_guard_rst_seq_pkg::*;
#(
    parameter int CntWidth    = 16,
    parameter int PendWidth   = 4,
    parameter int RstCntWidth = 8,
    parameter int AckTimeout  = AckTimeoutDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ena_i,
    input  logic                   fault_i,
    input  logic                   sw_rst_i,
    input  logic [PendWidth-1:0]   wr_pend_i,
    input  logic [PendWidth-1:0]   rd_pend_i,
    input  logic [CntWidth-1:0]    drain_budget_i,
    input  logic [CntWidth-1:0]    cool_budget_i,
    output logic                   isolate_o,
    output logic                   rst_req_o,
    input  logic                   rst_stat_i,
    output logic                   busy_o,
    output logic                   irq_o,
    input  logic                   irq_clr_i,
    output logic [1:0]             cause_o,
    output logic [RstCntWidth-1:0] rst_cnt_o
`ifdef SLV_GUARD_RST_SEQ_ACK_TIMEOUT_EN
    ,
    output logic                   ack_err_o
`endif
);

    state_e                 state_q, state_d;
    cause_e                 cause_q, cause_d;
    logic                   irq_q, irq_set;
    logic                   isolate_q, rst_req_q;
    logic [RstCntWidth-1:0] rst_cnt_q;
    logic                   cnt_inc;
    logic                   tmr_load, tmr_en, tmr_zero;
    logic [CntWidth-1:0]    tmr_val;
    logic                   is_fault, trigger, drained;
    logic                   ack_expire, ack_fail, ack_err_d, blocked;

    assign is_fault = ena_i & fault_i;
    assign trigger  = (is_fault | sw_rst_i) & ~blocked;
    assign drained  = (wr_pend_i == '0) && (rd_pend_i == '0);
    assign tmr_en   = (state_q == StDrain) || (state_q == StCool);

    slv_guard_timer #(
        .CntWidth (CntWidth)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        irq_set  = 1'b0;
        cnt_inc  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = drain_budget_i;
        ack_fail = 1'b0;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StIsolate;
                    cause_d = is_fault ? CauseFault : CauseSw;
                    irq_set = 1'b1;
                end
            end
            StIsolate: begin
                tmr_load = 1'b1;
                tmr_val  = drain_budget_i;
                state_d  = StDrain;
            end
            StDrain: begin
                // A clean drain wins over a timeout landing in the same cycle.
                if (drained) begin
                    state_d = StReq;
                end else if (tmr_zero) begin
                    state_d = StReq;
                    cause_d = CauseDrainTo;
                end
            end
            StReq: begin
                if (rst_stat_i) begin
                    state_d = StHold;
                end else if (ack_expire) begin
                    state_d  = StIdle;
                    ack_fail = 1'b1;
                    irq_set  = 1'b1;
                end
            end
            StHold: begin
                if (!rst_stat_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = cool_budget_i;
                    state_d  = StCool;
                end else if (ack_expire) begin
                    state_d  = StIdle;
                    ack_fail = 1'b1;
                    irq_set  = 1'b1;
                end
            end
            StCool: begin
                if (tmr_zero) begin
                    state_d = StIdle;
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cause_q   <= CauseNone;
            irq_q     <= 1'b0;
            isolate_q <= 1'b0;
            rst_req_q <= 1'b0;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            irq_q     <= irq_set | (irq_q & ~irq_clr_i);
            isolate_q <= (state_d != StIdle) | ack_err_d;
            rst_req_q <= (state_d == StReq);
            if (cnt_inc && (rst_cnt_q != '1)) begin
                rst_cnt_q <= rst_cnt_q + 1'b1;
            end
        end
    end

`ifdef SLV_GUARD_RST_SEQ_ACK_TIMEOUT_EN
    localparam int AckW = ack_cnt_width(AckTimeout);

    logic [AckW-1:0] ack_cnt_q;
    logic            ack_err_q;
    logic            ack_wait;

    assign ack_wait   = (state_q == StReq) || (state_q == StHold);
    assign ack_expire = ack_wait && (ack_cnt_q == AckW'(AckTimeout - 1));
    assign ack_err_d  = ack_err_q | ack_fail;
    assign blocked    = ack_err_q;
    assign ack_err_o  = ack_err_q;

    // Counter restarts on every state change so REQ and HOLD each get a full window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_cnt_q <= '0;
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack_err_d;
            if ((state_d != state_q) || !ack_wait) begin
                ack_cnt_q <= '0;
            end else begin
                ack_cnt_q <= ack_cnt_q + 1'b1;
            end
        end
    end
`else
    assign ack_expire = 1'b0;
    assign ack_err_d  = ack_fail;
    assign blocked    = 1'b0;
`endif

    assign isolate_o = isolate_q;
    assign rst_req_o = rst_req_q;
    assign busy_o    = (state_q != StIdle);
    assign irq_o     = irq_q;
    assign cause_o   = cause_q;
    assign rst_cnt_o = rst_cnt_q;

endmodule

// File: tb/tb_slv_guard_rst_seq.sv
// Directed bench for slv_guard_rst_seq; inputs change and outputs are sampled on the falling edge.
module tb_slv_guard_rst_seq;

    localparam int CntWidth    = 16;
    localparam int PendWidth   = 4;
    localparam int RstCntWidth = 8;

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   ena_i = 1'b1;
    logic                   fault_i = 1'b0;
    logic                   sw_rst_i = 1'b0;
    logic [PendWidth-1:0]   wr_pend_i = '0;
    logic [PendWidth-1:0]   rd_pend_i = '0;
    logic [CntWidth-1:0]    drain_budget_i = '0;
    logic [CntWidth-1:0]    cool_budget_i = '0;
    logic                   isolate_o;
    logic                   rst_req_o;
    logic                   rst_stat_i = 1'b0;
    logic                   busy_o;
    logic                   irq_o;
    logic                   irq_clr_i = 1'b0;
    logic [1:0]             cause_o;
    logic [RstCntWidth-1:0] rst_cnt_o;
`ifdef SLV_GUARD_RST_SEQ_ACK_TIMEOUT_EN
    logic                   ack_err_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    slv_guard_rst_seq #(
        .CntWidth    (CntWidth),
        .PendWidth   (PendWidth),
        .RstCntWidth (RstCntWidth),
        .AckTimeout  (16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .ena_i          (ena_i),
        .fault_i        (fault_i),
        .sw_rst_i       (sw_rst_i),
        .wr_pend_i      (wr_pend_i),
        .rd_pend_i      (rd_pend_i),
        .drain_budget_i (drain_budget_i),
        .cool_budget_i  (cool_budget_i),
        .isolate_o      (isolate_o),
        .rst_req_o      (rst_req_o),
        .rst_stat_i     (rst_stat_i),
        .busy_o         (busy_o),
        .irq_o          (irq_o),
        .irq_clr_i      (irq_clr_i),
        .cause_o        (cause_o),
        .rst_cnt_o      (rst_cnt_o)
`ifdef SLV_GUARD_RST_SEQ_ACK_TIMEOUT_EN
        ,
        .ack_err_o      (ack_err_o)
`endif
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input int max);
        int i;
        i = 0;
        while (rst_req_o !== 1'b1 && i < max) begin
            tick();
            i++;
        end
        check("req_up", {31'd0, rst_req_o}, 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        while (busy_o !== 1'b0 && i < max) begin
            tick();
            i++;
        end
        check("back_idle", {31'd0, busy_o}, 32'd0);
    endtask

    // Acts as the SoC reset controller for one handshake, then waits out the cooldown.
    task automatic finish_seq();
        wait_req(40);
        rst_stat_i = 1'b1;
        tick();
        rst_stat_i = 1'b0;
        wait_idle(40);
        exp_cnt++;
    endtask

    task automatic run_sw_seq();
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        finish_seq();
    endtask

    initial begin
        tick(2);
        check("rst_isolate", {31'd0, isolate_o}, 32'd0);
        check("rst_req",     {31'd0, rst_req_o}, 32'd0);
        check("rst_busy",    {31'd0, busy_o},    32'd0);
        check("rst_irq",     {31'd0, irq_o},     32'd0);
        check("rst_cause",   {30'd0, cause_o},   32'd0);
        check("rst_cnt",     {24'd0, rst_cnt_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        // Fault with outstanding traffic that drains before the budget runs out
        wr_pend_i = 4'd2; rd_pend_i = 4'd1; drain_budget_i = 16'd50; cool_budget_i = 16'd4;
        fault_i = 1'b1;
        tick();
        fault_i = 1'b0;
        check("t1_busy",    {31'd0, busy_o},    32'd1);
        check("t1_isolate", {31'd0, isolate_o}, 32'd1);
        check("t1_cause",   {30'd0, cause_o},   32'd1);
        check("t1_irq",     {31'd0, irq_o},     32'd1);
        tick(9);
        check("t1_no_req_yet", {31'd0, rst_req_o}, 32'd0);
        wr_pend_i = '0; rd_pend_i = '0;
        tick();
        check("t1_req", {31'd0, rst_req_o}, 32'd1);
        tick(2);
        rst_stat_i = 1'b1;
        tick();
        check("t1_req_drop", {31'd0, rst_req_o}, 32'd0);
        check("t1_hold_iso", {31'd0, isolate_o}, 32'd1);
        tick(5);
        rst_stat_i = 1'b0;
        tick(5);
        check("t1_cool_iso", {31'd0, isolate_o}, 32'd1);
        tick();
        check("t1_iso_drop", {31'd0, isolate_o}, 32'd0);
        check("t1_busy_end", {31'd0, busy_o},    32'd0);
        check("t1_cnt",      {24'd0, rst_cnt_o}, 32'd1);
        check("t1_cause_end", {30'd0, cause_o},  32'd1);
        check("t1_irq_end",  {31'd0, irq_o},     32'd1);
        exp_cnt = 1;

        // Software reset with writes that never drain: budget of 8 times out
        wr_pend_i = 4'd3; drain_budget_i = 16'd8;
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        check("t2_cause_sw", {30'd0, cause_o}, 32'd2);
        tick(2);
        drain_budget_i = 16'd1000;
        tick(7);
        check("t2_no_req_yet", {31'd0, rst_req_o}, 32'd0);
        tick();
        check("t2_req",      {31'd0, rst_req_o}, 32'd1);
        check("t2_cause_to", {30'd0, cause_o},   32'd3);
        wr_pend_i = '0; drain_budget_i = '0;
        finish_seq();
        check("t2_cnt", {24'd0, rst_cnt_o}, 32'd2);

        // Fault and software together, then a fault while disabled
        fault_i = 1'b1; sw_rst_i = 1'b1;
        tick();
        fault_i = 1'b0; sw_rst_i = 1'b0;
        check("t3_both_cause", {30'd0, cause_o}, 32'd1);
        finish_seq();
        ena_i = 1'b0; fault_i = 1'b1;
        tick(3);
        check("t3_dis_busy",  {31'd0, busy_o},  32'd0);
        check("t3_dis_cause", {30'd0, cause_o}, 32'd1);
        fault_i = 1'b0; ena_i = 1'b1;

        // irq clear alone, then clear coinciding with a new trigger
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        check("t4_irq_clr", {31'd0, irq_o}, 32'd0);
        sw_rst_i = 1'b1; irq_clr_i = 1'b1;
        tick();
        sw_rst_i = 1'b0; irq_clr_i = 1'b0;
        check("t4_irq_set_wins", {31'd0, irq_o}, 32'd1);
        finish_seq();

        // Drive the counter to saturation
        cool_budget_i = '0;
        while (exp_cnt < 255) run_sw_seq();
        check("t5_cnt_255", {24'd0, rst_cnt_o}, 32'd255);
        run_sw_seq();
        check("t5_cnt_sat", {24'd0, rst_cnt_o}, (exp_cnt > 255) ? 32'd255 : exp_cnt);

        // Asynchronous reset while the reset request is up
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        wait_req(20);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_req",     {31'd0, rst_req_o}, 32'd0);
        check("t6_isolate", {31'd0, isolate_o}, 32'd0);
        check("t6_busy",    {31'd0, busy_o},    32'd0);
        check("t6_irq",     {31'd0, irq_o},     32'd0);
        check("t6_cause",   {30'd0, cause_o},   32'd0);
        check("t6_cnt",     {24'd0, rst_cnt_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

`ifdef SLV_GUARD_RST_SEQ_ACK_TIMEOUT_EN
        // Reset controller never acknowledges: watchdog fires after 16 REQ cycles
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        wait_req(20);
        tick(15);
        check("t7_still_req", {31'd0, rst_req_o}, 32'd1);
        check("t7_no_err",    {31'd0, ack_err_o}, 32'd0);
        tick();
        check("t7_ack_err",   {31'd0, ack_err_o}, 32'd1);
        check("t7_isolate",   {31'd0, isolate_o}, 32'd1);
        check("t7_idle",      {31'd0, busy_o},    32'd0);
        check("t7_irq",       {31'd0, irq_o},     32'd1);
        check("t7_req_off",   {31'd0, rst_req_o}, 32'd0);
        fault_i = 1'b1;
        tick(2);
        fault_i = 1'b0;
        check("t7_ignored",   {31'd0, busy_o},    32'd0);
        check("t7_iso_stuck", {31'd0, isolate_o}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
